// File: rtl/vu_rnum_seq.sv
// Register-number decode and write-enable sequencer for one vector-unit slice.
// Drives one-hot true/complement store, load and VD rails and runs the transpose-load burst.
module vu_rnum_seq #(
  parameter int NREG   = 32,
  parameter int NSLICE = 8,
  parameter int NBWE   = 2,
  parameter int AW     = $clog2(NREG),
  parameter int SW     = $clog2(NSLICE)
) (
  input  logic                 clk,
  input  logic                 reset_l,
  input  logic [SW-1:0]        slice,
  input  logic [AW-1:0]        st_rnum,
  input  logic [AW-1:0]        xp_rnum,
  input  logic                 xpose,
  input  logic                 ld_valid,
  output logic                 ld_ready,
  input  logic [AW-1:0]        ld_rnum,
  input  logic [NBWE-1:0]      ld_bwe,
  input  logic                 ld_burst,
  input  logic [AW-1:0]        vd,
  input  logic                 wbv_wr_en,
  input  logic                 wb_div_type,
  input  logic [SW-1:0]        wb_div_elem,
  output logic [NREG-1:0]      rf_st_t,
  output logic [NREG-1:0]      rf_st_f,
  output logic [NBWE*NREG-1:0] rf_ld_t,
  output logic [NBWE*NREG-1:0] rf_ld_f,
  output logic [NREG-1:0]      rf_vd_t,
  output logic [NREG-1:0]      rf_vd_f,
  output logic                 busy,
  output logic                 wr_conflict
);

  typedef enum logic {IDLE, BURST} state_t;

  state_t              state, state_next;
  logic [SW-1:0]       beat, beat_next, beat_inc;
  logic [AW-1:0]       lat_rnum;
  logic [NBWE-1:0]     lat_bwe;

  logic [AW-1:0]       st_addr;
  logic [AW-1:0]       ld_addr;
  logic [NBWE-1:0]     bwe_sel;
  logic                ld_fire;
  logic [NREG-1:0]     ld_onehot;
  logic [NBWE*NREG-1:0] ld_next;
  logic [NREG-1:0]     ld_any;
  logic [NREG-1:0]     vd_next;
  logic                write_this;
  logic                conflict_next;

  // Low SW bits rotate by slice (+beat) modulo NSLICE; upper bits pass through.
  function automatic logic [AW-1:0] xpose_addr(input logic [AW-1:0] base,
                                               input logic [SW-1:0] sl,
                                               input logic [SW-1:0] bt);
    logic [AW-1:0] r;
    r = base;
    r[SW-1:0] = base[SW-1:0] + sl + bt;
    return r;
  endfunction

  function automatic logic [NREG-1:0] onehot(input logic [AW-1:0] a);
    logic [NREG-1:0] r;
    r = '0;
    r[a] = 1'b1;
    return r;
  endfunction

  always_comb begin
    st_addr = xpose ? xpose_addr(xp_rnum, slice, '0) : st_rnum;
    rf_st_t = onehot(st_addr);
    rf_st_f = ~rf_st_t;
  end

  assign ld_ready = (state == IDLE);
  assign busy     = (state == BURST);
  assign beat_inc = beat + SW'(1);

  // Beat 0 is registered on the accept edge, so the BURST state issues beats 1..NSLICE-1
  // and its final cycle (beat NSLICE-1 on the rails) issues nothing.
  always_comb begin
    state_next = state;
    beat_next  = beat;
    ld_addr    = '0;
    bwe_sel    = '0;
    ld_fire    = 1'b0;
    case (state)
      IDLE: begin
        if (ld_valid) begin
          ld_fire = 1'b1;
          bwe_sel = ld_bwe;
          if (ld_burst) begin
            state_next = BURST;
            beat_next  = '0;
            ld_addr    = xpose_addr(ld_rnum, slice, '0);
          end else begin
            ld_addr = xpose ? xpose_addr(ld_rnum, slice, '0) : ld_rnum;
          end
        end
      end
      BURST: begin
        if (beat == SW'(NSLICE - 1)) begin
          state_next = IDLE;
          beat_next  = '0;
        end else begin
          beat_next = beat_inc;
          ld_fire   = 1'b1;
          bwe_sel   = lat_bwe;
          ld_addr   = xpose_addr(lat_rnum, slice, beat_inc);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    ld_onehot = onehot(ld_addr);
    ld_next   = '0;
    ld_any    = '0;
    for (int unsigned l = 0; l < NBWE; l++) begin
      ld_next[l*NREG +: NREG] = (ld_fire && bwe_sel[l]) ? ld_onehot : '0;
      ld_any = ld_any | ld_next[l*NREG +: NREG];
    end
    write_this    = wbv_wr_en && (!wb_div_type || (wb_div_elem == slice));
    vd_next       = write_this ? onehot(vd) : '0;
    conflict_next = |(ld_any & vd_next);
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state       <= IDLE;
      beat        <= '0;
      lat_rnum    <= '0;
      lat_bwe     <= '0;
      rf_ld_t     <= '0;
      rf_vd_t     <= '0;
      wr_conflict <= 1'b0;
    end else begin
      state       <= state_next;
      beat        <= beat_next;
      rf_ld_t     <= ld_next;
      rf_vd_t     <= vd_next;
      wr_conflict <= conflict_next;
      if (state == IDLE && ld_valid && ld_burst) begin
        lat_rnum <= ld_rnum;
        lat_bwe  <= ld_bwe;
      end
    end
  end

  assign rf_ld_f = ~rf_ld_t;
  assign rf_vd_f = ~rf_vd_t;

endmodule

// File: doc/vu_rnum_seq.md
# vu_rnum_seq

Parametrised register-number decode and write-enable sequencer for one vector-unit datapath slice. Decodes the store-read, load-write and VD-write register addresses into one-hot true/false enable rails for an NREG-entry register file. Applies slice-relative transpose offsets and gates divide-unit writebacks to the owning element. Adds a multi-beat transpose-load sequencer with a valid/ready handshake, plus a same-cycle write-conflict flag. Sits between the vector control pipeline and the register-file macro of each datapath.

## Interface
Parameters:
- NREG, 32, number of vector registers; power of two, ≥ NSLICE
- NSLICE, 8, slices per datapath; power of two, ≥ 2
- NBWE, 2, load-port byte-write-enable lanes
- AW, log2(NREG), register-address width (derived)
- SW, log2(NSLICE), slice-index width (derived)

Ports:
- clk  in  1  clock; all state on rising edge
- reset_l  in  1  asynchronous, active-low reset
- slice  in  SW  static slice index of this datapath
- st_rnum  in  AW  store-port register, RD stage
- xp_rnum  in  AW  store-port transpose base register, RD stage
- xpose  in  1  transpose mode for store and single-beat load
- ld_valid  in  1  load request valid
- ld_ready  out  1  block can accept load request
- ld_rnum  in  AW  load base register
- ld_bwe  in  NBWE  load byte-write-enables
- ld_burst  in  1  with ld_valid: run an NSLICE-beat transpose load
- vd  in  AW  WB-stage destination register
- wbv_wr_en  in  1  WB datapath write enable
- wb_div_type  in  1  WB result is a single-element divide result
- wb_div_elem  in  SW  element owning the divide result
- rf_st_t / rf_st_f  out  NREG  store read select, true/complement
- rf_ld_t / rf_ld_f  out  NBWE*NREG  load write enable, lane-major ([l*NREG+r]), true/complement
- rf_vd_t / rf_vd_f  out  NREG  VD write enable, true/complement
- busy  out  1  burst in progress
- wr_conflict  out  1  load and VD enables hit the same register this cycle

## Operation
- Transpose address: low SW bits = (base[SW-1:0] + slice [+ beat]) mod NSLICE; upper AW-SW bits pass unchanged; carries discarded.
- Store port: combinational. Register = xpose ? transposed(xp_rnum) : st_rnum. rf_st_t is one-hot at all times, including during reset, because the read ports must always be driven. rf_st_f = ~rf_st_t.
- Load accept: ld_valid && ld_ready.
  - Single beat (ld_burst=0): register = xpose ? transposed(ld_rnum) : ld_rnum. Lane l is enabled iff ld_bwe[l].
  - Burst (ld_burst=1): latch ld_rnum and ld_bwe. Beat k (0..NSLICE-1) targets transposed(ld_rnum, beat=k) with the latched bwe. xpose is ignored.
- FSM:
  - IDLE: ld_ready=1, busy=0. Burst accept → BURST, beat=0.
  - BURST: ld_ready=0, busy=1. Each cycle issues beat and increments it. After beat NSLICE-1 is issued → IDLE.
- VD: write_this = wbv_wr_en && (!wb_div_type || wb_div_elem==slice). VD enable = onehot(vd) & write_this.
- Conflict: wr_conflict=1 iff the registered load enable (any lane) and the registered VD enable share a register index. Both enables are still driven; VD has no priority logic here.
- Every _f rail is the exact bitwise complement of its _t rail.

## Timing
- Store select: 0 cycles, combinational.
- Load enable: registered. An accept (or a burst beat) in cycle N drives rf_ld_t in cycle N+1 for exactly one cycle. A burst produces NSLICE consecutive one-cycle pulses in N+1..N+NSLICE.
- ld_ready returns high in the cycle after beat NSLICE-1 is issued. Back-to-back single-beat loads are accepted every cycle.
- VD enable: registered, 1 cycle after WB inputs. wr_conflict is registered alongside.
- Reset (asynchronous, any time, including mid-burst) forces:
  - rf_ld_t=0, rf_ld_f=all 1s
  - rf_vd_t=0, rf_vd_f=all 1s
  - wr_conflict=0, busy=0
  - FSM=IDLE, beat=0
  - ld_ready=1 from the first cycle after reset deassertion
  - the partial burst is abandoned, not resumed
- ld_valid while ld_ready=0: ignored, no enable produced.
- No enable pulse ever lasts more than one cycle. An idle cycle (no accept, no write_this) drives all-zero rf_ld_t and rf_vd_t.

## Test plan
- Store transpose: NREG=32, NSLICE=8, slice=5, xpose=1, xp_rnum=0x0E → rf_st_t=1<<11 (0x0E low bits 6+5=11 mod 8=3, upper bits 0x08 → reg 0x0B), same cycle. With xpose=0, st_rnum=7 → rf_st_t=0x80.
- Single load: ld_valid=1, ld_rnum=3, ld_bwe=2'b10, xpose=0 in cycle N → cycle N+1 rf_ld_t lane1 bit 3 only, lane0 all zero, rf_ld_f its complement. Cycle N+2: all zero.
- Burst: slice=2, ld_rnum=0x10, ld_bwe=2'b11, ld_burst=1 → regs 0x12,0x13,…,0x17,0x10,0x11 in cycles N+1..N+8, both lanes. ld_ready low N+1..N+8 and high at N+9. A mid-burst ld_valid is ignored.
- Divide gating: slice=4, wbv_wr_en=1, wb_div_type=1, vd=9. wb_div_elem=4 → rf_vd_t=1<<9 next cycle. wb_div_elem=3 → rf_vd_t=0.
- Conflict: single load to reg 9 and VD write to reg 9 in the same cycle → next cycle both enables set bit 9 and wr_conflict=1. Regs 9 vs 10 → wr_conflict=0.
- Reset mid-burst: assert reset_l=0 at beat 3 → immediately rf_ld_t=0, rf_ld_f all 1s, busy=0. After release, ld_ready=1 and a fresh single load works normally.
